dm_hart_ctrl: RTL and testbench

- Multi-hart run-control engine for the debug module; generalises the single-hart halt_req/hartreset/ndmreset outputs to NHARTS harts.
- Decodes dmcontrol and hawindow writes into per-hart request levels.
- Tracks resumeack, havereset and resethaltreq per hart, and produces the dmstatus any*/all* summary over the selected harts.
- Sits entirely in dm_clk, between the DM register file and the cores' debug interfaces.

---
 rtl/dm_pkg.sv | 62 ++++++
 rtl/dm_hart_slot.sv | 86 ++++++++
 rtl/dm_hart_ctrl.sv | 153 +++++++++++++++
 tb/tb_dm_hart_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared debug-module definitions: dmcontrol field positions, dmstatus summary
// bit indices and the dmcontrol decode used by the run-control engine.
package dm_pkg;

  localparam int HARTSEL_W = 20;
  localparam int STATUS_W  = 12;

  localparam int DMC_HALTREQ         = 31;
  localparam int DMC_RESUMEREQ       = 30;
  localparam int DMC_HARTRESET       = 29;
  localparam int DMC_ACKHAVERESET    = 28;
  localparam int DMC_HASEL           = 26;
  localparam int DMC_HARTSELLO_LSB   = 16;
  localparam int DMC_HARTSELHI_LSB   = 6;
  localparam int DMC_SETRESETHALTREQ = 3;
  localparam int DMC_CLRRESETHALTREQ = 2;
  localparam int DMC_NDMRESET        = 1;
  localparam int DMC_DMACTIVE        = 0;

  localparam int ST_ANYHALTED      = 0;
  localparam int ST_ALLHALTED      = 1;
  localparam int ST_ANYRUNNING     = 2;
  localparam int ST_ALLRUNNING     = 3;
  localparam int ST_ANYUNAVAIL     = 4;
  localparam int ST_ALLUNAVAIL     = 5;
  localparam int ST_ANYNONEXISTENT = 6;
  localparam int ST_ALLNONEXISTENT = 7;
  localparam int ST_ANYRESUMEACK   = 8;
  localparam int ST_ALLRESUMEACK   = 9;
  localparam int ST_ANYHAVERESET   = 10;
  localparam int ST_ALLHAVERESET   = 11;

  typedef struct packed {
    logic                 haltreq;
    logic                 resumereq;
    logic                 hartreset;
    logic                 ackhavereset;
    logic                 hasel;
    logic [HARTSEL_W-1:0] hartsel;
    logic                 setresethaltreq;
    logic                 clrresethaltreq;
    logic                 ndmreset;
    logic                 dmactive;
  } dmcontrol_t;

  // hartsel is {hartselhi, hartsello}: the low 10 bits live in [25:16].
  function automatic dmcontrol_t decode_dmcontrol(input logic [31:0] w);
    dmcontrol_t d;
    d.haltreq         = w[DMC_HALTREQ];
    d.resumereq       = w[DMC_RESUMEREQ];
    d.hartreset       = w[DMC_HARTRESET];
    d.ackhavereset    = w[DMC_ACKHAVERESET];
    d.hasel           = w[DMC_HASEL];
    d.hartsel         = {w[DMC_HARTSELHI_LSB +: 10], w[DMC_HARTSELLO_LSB +: 10]};
    d.setresethaltreq = w[DMC_SETRESETHALTREQ];
    d.clrresethaltreq = w[DMC_CLRRESETHALTREQ];
    d.ndmreset        = w[DMC_NDMRESET];
    d.dmactive        = w[DMC_DMACTIVE];
    return d;
  endfunction

endpackage

// File: rtl/dm_hart_slot.sv
// Per-hart run-control state: halt/resume/reset requests, resume acknowledge,
// havereset and the halt-on-reset request.
module dm_hart_slot (
  input  logic clk,
  input  logic srst,
  input  logic sel,
  input  logic wr_apply,
  input  logic wr_deact,
  input  logic haltreq,
  input  logic resumereq,
  input  logic hartreset_wr,
  input  logic ackhavereset,
  input  logic setresethaltreq,
  input  logic clrresethaltreq,
  input  logic halted,
  input  logic rst_done,
  output logic halt_req,
  output logic resume_req,
  output logic hartreset,
  output logic resumeack,
  output logic havereset
);

  logic halt_req_reg;
  logic resume_req_reg;
  logic hartreset_reg;
  logic resumeack_reg;
  logic havereset_reg;
  logic resethaltreq_reg;
  logic wr_sel;

  assign wr_sel = wr_apply & sel;

  always_ff @(posedge clk) begin
    if (srst) begin
      halt_req_reg     <= 1'b0;
      resume_req_reg   <= 1'b0;
      hartreset_reg    <= 1'b0;
      resumeack_reg    <= 1'b0;
      havereset_reg    <= 1'b1;
      resethaltreq_reg <= 1'b0;
    end else begin
      if (wr_deact) begin
        // Deactivation drops every request; resumeack/havereset are history.
        halt_req_reg     <= 1'b0;
        resume_req_reg   <= 1'b0;
        hartreset_reg    <= 1'b0;
        resethaltreq_reg <= 1'b0;
      end else begin
        if (rst_done && resethaltreq_reg)
          halt_req_reg <= 1'b1;
        else if (wr_sel)
          halt_req_reg <= haltreq;

        // A fresh resume request restarts the handshake even if one is completing.
        if (wr_sel && resumereq && !haltreq) begin
          resume_req_reg <= 1'b1;
          resumeack_reg  <= 1'b0;
        end else if (resume_req_reg && !halted) begin
          resume_req_reg <= 1'b0;
          resumeack_reg  <= 1'b1;
        end

        if (wr_sel)
          hartreset_reg <= hartreset_wr;

        if (wr_sel && clrresethaltreq)
          resethaltreq_reg <= 1'b0;
        else if (wr_sel && setresethaltreq)
          resethaltreq_reg <= 1'b1;
      end

      if (rst_done)
        havereset_reg <= 1'b1;
      else if (wr_sel && ackhavereset)
        havereset_reg <= 1'b0;
    end
  end

  assign halt_req   = halt_req_reg;
  assign resume_req = resume_req_reg;
  assign hartreset  = hartreset_reg;
  assign resumeack  = resumeack_reg;
  assign havereset  = havereset_reg;

endmodule

// File: rtl/dm_hart_ctrl.sv
// Multi-hart run-control engine: decodes dmcontrol/hawindow writes into
// per-hart requests and produces the registered dmstatus any/all summary.
module dm_hart_ctrl
  import dm_pkg::*;
#(
  parameter int NHARTS     = 4,
  parameter int HARTSELLEN = (NHARTS > 1) ? $clog2(NHARTS) : 1
) (
  input  logic                 dm_clk,
  input  logic                 dm_rst,
  input  logic                 ctl_wen,
  input  logic [31:0]          ctl_wdata,
  input  logic                 hawin_wen,
  input  logic [31:0]          hawin_wdata,
  input  logic [NHARTS-1:0]    hart_halted,
  input  logic [NHARTS-1:0]    hart_unavail,
  input  logic [NHARTS-1:0]    hart_rst_done,
  output logic [NHARTS-1:0]    halt_req,
  output logic [NHARTS-1:0]    resume_req,
  output logic [NHARTS-1:0]    hartreset,
  output logic                 ndmreset,
  output logic                 dmactive,
  output logic [STATUS_W-1:0]  status,
  output logic [HARTSEL_W-1:0] hartsel_rd,
  output logic [31:0]          hawindow_rd
);

  localparam logic [HARTSELLEN:0] NHARTS_W = (HARTSELLEN + 1)'(NHARTS);

  logic [HARTSELLEN-1:0] hartsel_reg;
  logic                  hasel_reg;
  logic [NHARTS-1:0]     hawindow_reg;
  logic                  ndmreset_reg;
  logic                  dmactive_reg;
  logic [STATUS_W-1:0]   status_reg;
  logic [STATUS_W-1:0]   status_next;

  dmcontrol_t            dmc;
  logic                  wr_apply;
  logic                  wr_deact;
  logic [HARTSELLEN-1:0] wr_hartsel;
  logic [NHARTS-1:0]     win_eff;
  logic [NHARTS-1:0]     sel_wr;
  logic [NHARTS-1:0]     sel_cur;
  logic [NHARTS-1:0]     resumeack_vec;
  logic [NHARTS-1:0]     havereset_vec;
  logic                  nonexist_sel;
  logic                  unused_bits;

  assign dmc        = decode_dmcontrol(ctl_wdata);
  assign wr_apply   = ctl_wen & dmc.dmactive;
  assign wr_deact   = ctl_wen & ~dmc.dmactive;
  assign wr_hartsel = dmc.hartsel[HARTSELLEN-1:0];
  // A same-cycle hawindow write is visible to the dmcontrol write's selection.
  assign win_eff    = hawin_wen ? hawin_wdata[NHARTS-1:0] : hawindow_reg;
  assign unused_bits = ^{ctl_wdata, hawin_wdata, dmc};

  genvar gi;
  generate
    for (gi = 0; gi < NHARTS; gi++) begin : g_hart
      assign sel_wr[gi]  = (wr_hartsel == HARTSELLEN'(gi)) | (dmc.hasel & win_eff[gi]);
      assign sel_cur[gi] = (hartsel_reg == HARTSELLEN'(gi)) | (hasel_reg & hawindow_reg[gi]);

      dm_hart_slot u_slot (
        .clk             (dm_clk),
        .srst            (dm_rst),
        .sel             (sel_wr[gi]),
        .wr_apply        (wr_apply),
        .wr_deact        (wr_deact),
        .haltreq         (dmc.haltreq),
        .resumereq       (dmc.resumereq),
        .hartreset_wr    (dmc.hartreset),
        .ackhavereset    (dmc.ackhavereset),
        .setresethaltreq (dmc.setresethaltreq),
        .clrresethaltreq (dmc.clrresethaltreq),
        .halted          (hart_halted[gi]),
        .rst_done        (hart_rst_done[gi]),
        .halt_req        (halt_req[gi]),
        .resume_req      (resume_req[gi]),
        .hartreset       (hartreset[gi]),
        .resumeack       (resumeack_vec[gi]),
        .havereset       (havereset_vec[gi])
      );
    end
  endgenerate

  assign nonexist_sel = ({1'b0, hartsel_reg} >= NHARTS_W);

  function automatic logic any_of(input logic [NHARTS-1:0] s, input logic [NHARTS-1:0] st);
    return |(s & st);
  endfunction

  // A selected nonexistent hart is in no other state, so it defeats every all*.
  function automatic logic all_of(input logic [NHARTS-1:0] s, input logic [NHARTS-1:0] st,
                                  input logic nx);
    return (|s) & ~nx & (&(st | ~s));
  endfunction

  always_comb begin
    status_next = '0;
    status_next[ST_ANYHALTED]      = any_of(sel_cur, hart_halted);
    status_next[ST_ALLHALTED]      = all_of(sel_cur, hart_halted, nonexist_sel);
    status_next[ST_ANYRUNNING]     = any_of(sel_cur, ~hart_halted & ~hart_unavail);
    status_next[ST_ALLRUNNING]     = all_of(sel_cur, ~hart_halted & ~hart_unavail, nonexist_sel);
    status_next[ST_ANYUNAVAIL]     = any_of(sel_cur, hart_unavail);
    status_next[ST_ALLUNAVAIL]     = all_of(sel_cur, hart_unavail, nonexist_sel);
    status_next[ST_ANYNONEXISTENT] = nonexist_sel;
    status_next[ST_ALLNONEXISTENT] = nonexist_sel & ~(|sel_cur);
    status_next[ST_ANYRESUMEACK]   = any_of(sel_cur, resumeack_vec);
    status_next[ST_ALLRESUMEACK]   = all_of(sel_cur, resumeack_vec, nonexist_sel);
    status_next[ST_ANYHAVERESET]   = any_of(sel_cur, havereset_vec);
    status_next[ST_ALLHAVERESET]   = all_of(sel_cur, havereset_vec, nonexist_sel);
  end

  always_ff @(posedge dm_clk) begin
    if (dm_rst) begin
      hartsel_reg  <= '0;
      hasel_reg    <= 1'b0;
      hawindow_reg <= '0;
      ndmreset_reg <= 1'b0;
      dmactive_reg <= 1'b0;
      status_reg   <= '0;
    end else begin
      status_reg <= status_next;
      if (hawin_wen)
        hawindow_reg <= hawin_wdata[NHARTS-1:0];
      if (ctl_wen) begin
        dmactive_reg <= dmc.dmactive;
        ndmreset_reg <= dmc.dmactive & dmc.ndmreset;
        if (dmc.dmactive) begin
          hartsel_reg <= wr_hartsel;
          hasel_reg   <= dmc.hasel;
        end else begin
          hartsel_reg  <= '0;
          hasel_reg    <= 1'b0;
          hawindow_reg <= '0;
        end
      end
    end
  end

  always_comb begin
    hartsel_rd                   = '0;
    hartsel_rd[HARTSELLEN-1:0]   = hartsel_reg;
    hawindow_rd                  = '0;
    hawindow_rd[NHARTS-1:0]      = hawindow_reg;
  end

  assign ndmreset = ndmreset_reg;
  assign dmactive = dmactive_reg;
  assign status   = status_reg;

endmodule

// File: tb/tb_dm_hart_ctrl.sv
// Bench for dm_hart_ctrl: directed scenarios plus random traffic, all checked
// against a per-hart reference model evaluated every clock.
module tb_dm_hart_ctrl;

  localparam int N   = 4;
  localparam int HSL = 2;

  logic        dm_clk = 1'b0;
  logic        dm_rst;
  logic        ctl_wen;
  logic [31:0] ctl_wdata;
  logic        hawin_wen;
  logic [31:0] hawin_wdata;
  logic [N-1:0] hart_halted, hart_unavail, hart_rst_done;
  logic [N-1:0] halt_req, resume_req, hartreset;
  logic        ndmreset, dmactive;
  logic [11:0] status;
  logic [19:0] hartsel_rd;
  logic [31:0] hawindow_rd;

  // Second instance with a non-power-of-two hart count for nonexistent selection.
  logic        c3_ctl_wen;
  logic [31:0] c3_ctl_wdata;
  logic [2:0]  c3_halted;
  logic [2:0]  c3_halt_req, c3_resume_req, c3_hartreset;
  logic        c3_ndmreset, c3_dmactive;
  logic [11:0] c3_status;
  logic [19:0] c3_hartsel_rd;
  logic [31:0] c3_hawindow_rd;

  always #5 dm_clk = ~dm_clk;

  dm_hart_ctrl #(.NHARTS(N)) dut (
    .dm_clk(dm_clk), .dm_rst(dm_rst),
    .ctl_wen(ctl_wen), .ctl_wdata(ctl_wdata),
    .hawin_wen(hawin_wen), .hawin_wdata(hawin_wdata),
    .hart_halted(hart_halted), .hart_unavail(hart_unavail), .hart_rst_done(hart_rst_done),
    .halt_req(halt_req), .resume_req(resume_req), .hartreset(hartreset),
    .ndmreset(ndmreset), .dmactive(dmactive), .status(status),
    .hartsel_rd(hartsel_rd), .hawindow_rd(hawindow_rd)
  );

  dm_hart_ctrl #(.NHARTS(3)) dut3 (
    .dm_clk(dm_clk), .dm_rst(dm_rst),
    .ctl_wen(c3_ctl_wen), .ctl_wdata(c3_ctl_wdata),
    .hawin_wen(1'b0), .hawin_wdata(32'd0),
    .hart_halted(c3_halted), .hart_unavail(3'b000), .hart_rst_done(3'b000),
    .halt_req(c3_halt_req), .resume_req(c3_resume_req), .hartreset(c3_hartreset),
    .ndmreset(c3_ndmreset), .dmactive(c3_dmactive), .status(c3_status),
    .hartsel_rd(c3_hartsel_rd), .hawindow_rd(c3_hawindow_rd)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state, one entry per hart.
  bit m_halt[N], m_res[N], m_hrst[N], m_ack[N], m_hr[N], m_rhr[N], m_win[N];
  int m_hartsel;
  bit m_hasel, m_ndm, m_dmact;
  bit [11:0] m_status;

  function automatic logic [31:0] pack(input bit a[N]);
    logic [31:0] r = '0;
    for (int i = 0; i < N; i++) r[i] = a[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_halt[i] = 0; m_res[i] = 0; m_hrst[i] = 0; m_ack[i] = 0;
      m_hr[i] = 1; m_rhr[i] = 0; m_win[i] = 0;
    end
    m_hartsel = 0; m_hasel = 0; m_ndm = 0; m_dmact = 0;
  endtask

  // Count selected harts in each state; all* means every selected index qualifies.
  function automatic bit [11:0] model_status();
    int idx[$];
    int cnt[6];
    bit [11:0] st = '0;
    for (int i = 0; i < N; i++)
      if (m_hartsel == i || (m_hasel && m_win[i])) idx.push_back(i);
    if (m_hartsel >= N) idx.push_back(m_hartsel);
    for (int k = 0; k < 6; k++) cnt[k] = 0;
    foreach (idx[j]) begin
      int h = idx[j];
      if (h >= N) cnt[3]++;
      else begin
        if (hart_halted[h]) cnt[0]++;
        if (!hart_halted[h] && !hart_unavail[h]) cnt[1]++;
        if (hart_unavail[h]) cnt[2]++;
        if (m_ack[h]) cnt[4]++;
        if (m_hr[h]) cnt[5]++;
      end
    end
    for (int k = 0; k < 6; k++) begin
      st[2*k]   = (cnt[k] > 0);
      st[2*k+1] = (idx.size() > 0) && (cnt[k] == idx.size());
    end
    return st;
  endfunction

  task automatic model_update();
    bit win[N];
    bit act, deact, s, old_rhr;
    int hs;
    act   = ctl_wdata[0];
    deact = ctl_wen && !act;
    hs    = int'({ctl_wdata[15:6], ctl_wdata[25:16]}) % (1 << HSL);
    for (int i = 0; i < N; i++) win[i] = hawin_wen ? hawin_wdata[i] : m_win[i];
    for (int i = 0; i < N; i++) begin
      s = ctl_wen && act && (hs == i || (ctl_wdata[26] && win[i]));
      old_rhr = m_rhr[i];
      if (deact) begin
        m_halt[i] = 0; m_res[i] = 0; m_hrst[i] = 0; m_rhr[i] = 0;
      end else begin
        if (m_res[i] && !hart_halted[i]) begin m_res[i] = 0; m_ack[i] = 1; end
        if (s) begin
          m_halt[i] = ctl_wdata[31];
          m_hrst[i] = ctl_wdata[29];
          if (ctl_wdata[30] && !ctl_wdata[31]) begin m_res[i] = 1; m_ack[i] = 0; end
          if (ctl_wdata[3]) m_rhr[i] = 1;
          if (ctl_wdata[2]) m_rhr[i] = 0;
        end
        if (hart_rst_done[i] && old_rhr) m_halt[i] = 1;
      end
      if (s && ctl_wdata[28]) m_hr[i] = 0;
      if (hart_rst_done[i]) m_hr[i] = 1;
    end
    for (int i = 0; i < N; i++) m_win[i] = win[i];
    if (ctl_wen) begin
      m_dmact = act;
      m_ndm   = act && ctl_wdata[1];
      if (act) begin
        m_hartsel = hs; m_hasel = ctl_wdata[26];
      end else begin
        m_hartsel = 0; m_hasel = 0;
        for (int i = 0; i < N; i++) m_win[i] = 0;
      end
    end
  endtask

  task automatic compare_all();
    check_eq("halt_req",    32'(halt_req),    pack(m_halt));
    check_eq("resume_req",  32'(resume_req),  pack(m_res));
    check_eq("hartreset",   32'(hartreset),   pack(m_hrst));
    check_eq("ndmreset",    32'(ndmreset),    32'(m_ndm));
    check_eq("dmactive",    32'(dmactive),    32'(m_dmact));
    check_eq("status",      32'(status),      32'(m_status));
    check_eq("hartsel_rd",  32'(hartsel_rd),  32'(m_hartsel));
    check_eq("hawindow_rd", hawindow_rd,      pack(m_win));
  endtask

  task automatic tick();
    bit [11:0] st;
    if (dm_rst) begin
      @(posedge dm_clk); #1;
      model_reset();
      m_status = '0;
    end else begin
      st = model_status();
      model_update();
      @(posedge dm_clk); #1;
      m_status = st;
    end
    compare_all();
  endtask

  task automatic wr_ctl(input logic [31:0] d);
    ctl_wen = 1'b1; ctl_wdata = d;
    tick();
    ctl_wen = 1'b0; ctl_wdata = '0;
  endtask

  task automatic wr_win(input logic [31:0] d);
    hawin_wen = 1'b1; hawin_wdata = d;
    tick();
    hawin_wen = 1'b0; hawin_wdata = '0;
  endtask

  initial begin
    dm_rst = 1'b1;
    ctl_wen = 0; ctl_wdata = '0; hawin_wen = 0; hawin_wdata = '0;
    hart_halted = '0; hart_unavail = '0; hart_rst_done = '0;
    c3_ctl_wen = 0; c3_ctl_wdata = '0; c3_halted = '0;
    model_reset();
    m_status = '0;
    tick(); tick();
    check_eq("rst_status", 32'(status), 32'd0);
    dm_rst = 1'b0;

    // Reset summary and havereset acknowledge.
    wr_ctl(32'h0000_0001);
    tick();
    check_eq("rst_allhavereset", 32'(status[11]), 32'd1);
    check_eq("rst_anyhavereset", 32'(status[10]), 32'd1);
    check_eq("rst_allrunning",   32'(status[3]),  32'd1);
    wr_ctl(32'h1000_0001);
    tick();
    check_eq("ack_anyhavereset", 32'(status[10]), 32'd0);

    // Halt via hart array window.
    wr_win(32'h0000_000a);
    wr_ctl(32'h8400_0001);
    check_eq("ha_halt_req", 32'(halt_req), 32'hb);
    hart_halted = 4'b1011;
    tick();
    check_eq("ha_allhalted",  32'(status[1]), 32'd1);
    check_eq("ha_anyrunning", 32'(status[2]), 32'd0);

    // Resume handshake on hart 0.
    hart_halted = 4'b0001;
    wr_ctl(32'h4000_0001);
    check_eq("res_req", 32'(resume_req), 32'h1);
    tick();
    check_eq("res_anyack", 32'(status[8]), 32'd0);
    hart_halted = 4'b0000;
    tick();
    check_eq("res_req_done", 32'(resume_req), 32'h0);
    tick();
    check_eq("res_allack", 32'(status[9]), 32'd1);

    // WARL hartsel and nonexistent selection.
    wr_ctl(32'h0005_0001);
    check_eq("warl_hartsel", 32'(hartsel_rd), 32'd1);
    tick();
    check_eq("warl_anynonexist", 32'(status[6]), 32'd0);
    c3_ctl_wen = 1'b1; c3_ctl_wdata = 32'h0007_0001;
    tick();
    c3_ctl_wen = 1'b0; c3_ctl_wdata = '0;
    tick();
    check_eq("n3_hartsel",  32'(c3_hartsel_rd), 32'd3);
    check_eq("n3_status",   32'(c3_status), 32'h0c0);
    check_eq("n3_reqs",     32'({c3_halt_req, c3_resume_req, c3_hartreset}), 32'd0);
    check_eq("n3_ctl",      32'({c3_ndmreset, c3_dmactive}), 32'd1);
    check_eq("n3_hawindow", c3_hawindow_rd, 32'd0);

    // Halt on reset, and havereset set winning over acknowledge.
    wr_ctl(32'h0002_0009);
    hart_rst_done = 4'b0100;
    tick();
    hart_rst_done = '0;
    check_eq("rh_halt2", 32'(halt_req[2]), 32'd1);
    tick();
    check_eq("rh_havereset2", 32'(status[10]), 32'd1);
    hart_rst_done = 4'b0100;
    wr_ctl(32'h1002_0001);
    hart_rst_done = '0;
    tick();
    check_eq("rh_set_wins", 32'(status[10]), 32'd1);

    // Deactivate mid-operation, then reset mid-resume.
    hart_halted = 4'b1111;
    wr_ctl(32'h4000_0001);
    wr_win(32'h0000_000f);
    wr_ctl(32'h8400_0003);
    check_eq("da_halt_all", 32'(halt_req), 32'hf);
    check_eq("da_ndm",      32'(ndmreset), 32'd1);
    check_eq("da_pending",  32'(resume_req), 32'h1);
    wr_ctl(32'h0000_0000);
    check_eq("da_cleared", 32'({halt_req, resume_req, hartreset, ndmreset}), 32'd0);
    check_eq("da_hawindow", hawindow_rd, 32'd0);
    wr_ctl(32'h4000_0001);
    dm_rst = 1'b1;
    tick();
    dm_rst = 1'b0;
    check_eq("mr_outputs", 32'({halt_req, resume_req, hartreset, ndmreset, dmactive, hartsel_rd}), 32'd0);
    check_eq("mr_status",  32'(status), 32'd0);

    // Random traffic against the model.
    for (int it = 0; it < 2000; it++) begin
      ctl_wen   = ($urandom_range(0, 3) == 0);
      ctl_wdata = $urandom;
      ctl_wdata[0] = ($urandom_range(0, 9) != 0);
      hawin_wen   = ($urandom_range(0, 5) == 0);
      hawin_wdata = $urandom;
      if ($urandom_range(0, 3) == 0) hart_halted = 4'($urandom);
      if ($urandom_range(0, 7) == 0) hart_unavail = 4'($urandom & $urandom);
      hart_rst_done = 4'($urandom & $urandom & $urandom);
      dm_rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    dm_rst = 1'b0; ctl_wen = 0; hawin_wen = 0; hart_rst_done = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
